wb_bfm_slave_responder: RTL

- Parametrised Wishbone B3 classic slave model for the AXI-to-WB testbench. It terminates the bridge's WB master port.
- Backed by a byte-enabled word memory.
- Runtime-programmable wait states, retry injection and error injection.
- Window-checked addressing, plus an ack counter for scoreboard cross-checks.

---
 rtl/wb_bfm_pkg.sv | 32 +++
 rtl/wb_bfm_byte_mem.sv | 42 ++++
 rtl/wb_bfm_slave_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bfm_pkg.sv
// Shared types and helpers for the Wishbone B3 classic slave responder.
//   state_e : responder FSM states
//   rsp_e   : termination chosen on entry to the response state
//   idx_width / lane_shift : clog2-derived widths for word indexing
package wb_bfm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    RspAck,
    RspErr,
    RspRty
  } rsp_e;

  // Word index width; never zero so single-word memories still get a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Number of low byte-address bits dropped to form a word index.
  function automatic int unsigned lane_shift(input int unsigned sel_width);
    return (sel_width > 1) ? $clog2(sel_width) : 0;
  endfunction

  localparam int unsigned DefaultDepth = 256;
  localparam int unsigned DefaultIdxW  = idx_width(DefaultDepth);

endpackage

// File: rtl/wb_bfm_byte_mem.sv
// Depth x DataWidth word memory with per-byte-lane write enable.
//   clk_i, rst_ni : clock, async active-low reset (zero-fills every word)
//   we_i, be_i    : write strobe and byte-lane enables
//   idx_i         : word index shared by the write and the read port
//   wdata_i       : write data
//   rdata_o       : combinational read of word idx_i
module wb_bfm_byte_mem
  import wb_bfm_pkg::*;
#(
  parameter int unsigned Depth     = 256,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned SelW     = DataWidth / 8,
  localparam int unsigned IdxW     = idx_width(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [SelW-1:0]      be_i,
  input  logic [IdxW-1:0]      idx_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned l = 0; l < SelW; l++) begin
        if (be_i[l]) begin
          mem_q[idx_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/wb_bfm_slave_responder.sv
// Wishbone B3 classic slave model terminating a WB master port.
//   clk, rst (async, active-low)
//   wb_*            : WB slave interface (adr/dat/we/sel/stb/cyc in; dat/ack/err/rty out)
//   cfg_wait_i      : wait cycles before each termination
//   cfg_rty_cnt_i   : rty terminations issued before a transfer is accepted
//   cfg_err_en_i    : force err on every accepted request
//   stat_ack_cnt_o  : saturating count of ack terminations since reset
// A request sampled at edge N terminates during the cycle after edge N+1+cfg_wait_i.
module wb_bfm_slave_responder
  import wb_bfm_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           MEM_DEPTH    = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int unsigned           WAIT_W       = 4,
  parameter int unsigned           RTY_W        = 3,
  parameter int unsigned           CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_sel_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  input  logic [WAIT_W-1:0]       cfg_wait_i,
  input  logic [RTY_W-1:0]        cfg_rty_cnt_i,
  input  logic                    cfg_err_en_i,
  output logic [CNT_W-1:0]        stat_ack_cnt_o
);

  localparam int unsigned    IdxW      = idx_width(MEM_DEPTH);
  localparam int unsigned    LaneShift = lane_shift(SELECT_WIDTH);
  localparam longint unsigned MemBytes = 64'(MEM_DEPTH) * 64'(SELECT_WIDTH);

  state_e                  state_q, state_d;
  rsp_e                    rsp_q, rsp_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic                    we_q, we_d;
  logic [RTY_W-1:0]        budget_q, budget_d;
  logic                    reload_q, reload_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    rty_q, rty_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    req;
  logic                    term_q;
  logic                    enter_resp;
  logic [ADDR_WIDTH-1:0]   chk_adr;
  logic [ADDR_WIDTH-1:0]   chk_off;
  logic                    in_range;
  logic [ADDR_WIDTH-1:0]   mem_off;
  logic [IdxW-1:0]         mem_idx;
  logic [RTY_W-1:0]        eff_budget;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  assign req    = wb_cyc_i & wb_stb_i;
  assign term_q = ack_q | err_q | rty_q;

  // From IDLE with zero wait the request has not been latched yet, so check the live address.
  assign chk_adr  = (state_q == StIdle) ? wb_adr_i : adr_q;
  assign chk_off  = chk_adr - BASE_ADDR;
  assign in_range = (chk_adr >= BASE_ADDR) && (64'(chk_off) < MemBytes);

  assign mem_off = adr_q - BASE_ADDR;
  assign mem_idx = IdxW'(mem_off >> LaneShift);

  // Budget is reloaded lazily: the pending reload is resolved at the next RESP entry.
  assign eff_budget = reload_q ? cfg_rty_cnt_i : budget_q;

  always_comb begin
    state_d    = state_q;
    rsp_d      = rsp_q;
    wait_cnt_d = wait_cnt_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    budget_d   = budget_q;
    reload_d   = reload_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rty_d      = 1'b0;
    rdat_d     = '0;
    mem_we     = 1'b0;
    enter_resp = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Skip the cycle where our own termination is still visible to the master.
        if (req && !term_q) begin
          adr_d      = wb_adr_i;
          wdat_d     = wb_dat_i;
          sel_d      = wb_sel_i;
          we_d       = wb_we_i;
          wait_cnt_d = cfg_wait_i;
          if (cfg_wait_i == '0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (wait_cnt_q == WAIT_W'(1)) begin
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
        unique case (rsp_q)
          RspAck: begin
            ack_d    = 1'b1;
            mem_we   = we_q;
            rdat_d   = we_q ? '0 : mem_rdata;
            reload_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          RspErr: begin
            err_d    = 1'b1;
            reload_d = 1'b1;
          end
          RspRty: begin
            rty_d = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase

    if (enter_resp) begin
      state_d  = StResp;
      reload_d = 1'b0;
      budget_d = eff_budget;
      if (!in_range || cfg_err_en_i) begin
        rsp_d = RspErr;
      end else if (eff_budget != '0) begin
        rsp_d    = RspRty;
        budget_d = eff_budget - RTY_W'(1);
      end else begin
        rsp_d = RspAck;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rsp_q      <= RspAck;
      wait_cnt_q <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      budget_q   <= '0;
      reload_q   <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rty_q      <= 1'b0;
      rdat_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rsp_q      <= rsp_d;
      wait_cnt_q <= wait_cnt_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      budget_q   <= budget_d;
      reload_q   <= reload_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rty_q      <= rty_d;
      rdat_q     <= rdat_d;
      cnt_q      <= cnt_d;
    end
  end

  wb_bfm_byte_mem #(
    .Depth    (MEM_DEPTH),
    .DataWidth(DATA_WIDTH)
  ) u_mem (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (mem_we),
    .be_i   (sel_q),
    .idx_i  (mem_idx),
    .wdata_i(wdat_q),
    .rdata_o(mem_rdata)
  );

  assign wb_ack_o       = ack_q;
  assign wb_err_o       = err_q;
  assign wb_rty_o       = rty_q;
  assign wb_dat_o       = rdat_q;
  assign stat_ack_cnt_o = cnt_q;

endmodule
